// File: rtl/la_iosupplyseq.sv
// IO supply cell with ordered power sequencing of N switched supply domains.
// Define LA_IOSUPPLYSEQ_TIMEOUT_EN to fault on a missing power-good after TIMEOUT cycles.
module la_iosupplyseq #(
    parameter PROP = "DEFAULT",
    parameter SIDE = "NO",
    parameter int RINGW = 8,
    parameter int N = 4,
    parameter int CW = 16,
    parameter int DELAY = 8,
    parameter int TIMEOUT = 1000
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             en,
    input  logic [N-1:0]     pgood,
    output logic [N-1:0]     sw_en,
    output logic             ready,
    output logic             fault,
    output logic             busy,
    inout  logic             vdd,
    inout  logic             vss,
    inout  logic             vddio,
    inout  logic             vssio,
    inout  logic [RINGW-1:0] ioring
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [2:0] {
        IDLE,
        RAMP_WAIT,
        RAMP_SETTLE,
        ON,
        DOWN,
        FAULT
    } state_t;

    state_t         state, state_n;
    logic [IW-1:0]  idx, idx_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic [N-1:0]   sw_n;
    logic [N-1:0]   pg_m, pgood_s;

    // Supplies and ioring are connectivity only; this net keeps them visibly consumed.
    logic unused_ok;
    assign unused_ok = ^{vdd, vss, vddio, vssio, ioring, PROP, SIDE, 32'(TIMEOUT)};

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            pg_m    <= '0;
            pgood_s <= '0;
        end else begin
            pg_m    <= pgood;
            pgood_s <= pg_m;
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        cnt_n   = cnt;
        sw_n    = sw_en;
        case (state)
            IDLE: begin
                sw_n = '0;
                if (en) begin
                    state_n = RAMP_WAIT;
                    idx_n   = '0;
                    cnt_n   = '0;
                    sw_n[0] = 1'b1;
                end
            end
            RAMP_WAIT: begin
                if (!en) begin
                    state_n    = DOWN;
                    cnt_n      = '0;
                    sw_n[idx]  = 1'b0;
                end else if (pgood_s[idx]) begin
                    state_n = RAMP_SETTLE;
                    cnt_n   = '0;
`ifdef LA_IOSUPPLYSEQ_TIMEOUT_EN
                end else if (cnt == CW'(TIMEOUT)) begin
                    state_n = FAULT;
                    sw_n    = '0;
`endif
                end else if (cnt != '1) begin
                    cnt_n = cnt + 1'b1;
                end
            end
            RAMP_SETTLE: begin
                if (!en) begin
                    state_n   = DOWN;
                    cnt_n     = '0;
                    sw_n[idx] = 1'b0;
                end else if (cnt == CW'(DELAY)) begin
                    if (idx == IW'(N - 1)) begin
                        state_n = ON;
                    end else begin
                        state_n     = RAMP_WAIT;
                        idx_n       = idx + 1'b1;
                        cnt_n       = '0;
                        sw_n[idx_n] = 1'b1;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            ON: begin
                if (|(sw_en & ~pgood_s)) begin
                    state_n = FAULT;
                    sw_n    = '0;
                end else if (!en) begin
                    state_n   = DOWN;
                    cnt_n     = '0;
                    sw_n[idx] = 1'b0;
                end
            end
            DOWN: begin
                // Channel idx was released on entry; each step waits DELAY+1 edges.
                if (cnt == CW'(DELAY)) begin
                    cnt_n = '0;
                    if (idx == '0) begin
                        state_n = IDLE;
                    end else begin
                        idx_n       = idx - 1'b1;
                        sw_n[idx_n] = 1'b0;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            FAULT: begin
                sw_n = '0;
                if (!en) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                sw_n    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state <= IDLE;
            idx   <= '0;
            cnt   <= '0;
            sw_en <= '0;
            ready <= 1'b0;
            fault <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            cnt   <= cnt_n;
            sw_en <= sw_n;
            ready <= (state_n == ON);
            fault <= (state_n == FAULT);
            busy  <= (state_n == RAMP_WAIT) || (state_n == RAMP_SETTLE) || (state_n == DOWN);
        end
    end

endmodule
